// File: rtl/line_window_ctrl.sv
// Purpose: frame/line sequencer for the edge-detection window; tracks pixel (x,y), gates the line-delay chain.
// Latency: shift_en is combinational; out_* and frame_done appear PIPE_LAT cycles after the accepting edge.
// Backpressure: none; every pix_valid seen in ACTIVE (or with frame_start) is accepted unconditionally.
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   frame_start        - one-cycle pulse on the first pixel slot of a frame
//   pix_valid          - camera pixel present this cycle
//   shift_en           - enable for the line-delay chain (pixel accepted this cycle)
//   out_valid/out_border/out_x/out_y - delayed per-pixel strobe, border flag and coordinates
//   frame_done         - pulse coincident with the last out_valid of a complete frame
//   err_short          - pulse the cycle after a frame restarts mid-frame
//   frame_cnt          - completed-frame counter
// Optional feature: define LINE_WIN_STATS_EN to build frame_cnt and err_short; otherwise both are tied to 0.
module line_window_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int PIPE_LAT   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          pix_valid,
  output logic          shift_en,
  output logic          out_valid,
  output logic          out_border,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          frame_done,
  output logic          err_short,
  output logic [15:0]   frame_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic          vld;
    logic          border;
    logic          last;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pipe_t;

  logic [1:0]    state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          accept;
  logic          last_pix;
  pipe_t         pipe_in;
  pipe_t         pipe_q [PIPE_LAT];

  // frame_start in any state restarts the coordinates, so a coincident pixel is always (0,0).
  assign cur_x    = frame_start ? '0 : x_q;
  assign cur_y    = frame_start ? '0 : y_q;
  assign accept   = pix_valid & ((state_q == S_ACTIVE) | frame_start);
  assign shift_en = accept;
  assign last_pix = accept & (cur_x == X_LAST) & (cur_y == Y_LAST);

  always_comb begin
    pipe_in = '0;
    if (accept) begin
      pipe_in.vld    = 1'b1;
      // The 3x3 window centred at (x-1,y-1) is incomplete in the first two rows/columns.
      pipe_in.border = (cur_x < XW'(2)) | (cur_y < YW'(2));
      pipe_in.last   = last_pix;
      pipe_in.x      = cur_x;
      pipe_in.y      = cur_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (last_pix) begin
      state_q <= S_DONE;
    end else if (frame_start) begin
      state_q <= S_ACTIVE;
    end else if (state_q == S_DONE) begin
      state_q <= S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (cur_x == X_LAST) begin
        x_q <= '0;
        y_q <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_q <= cur_x + XW'(1);
        y_q <= cur_y;
      end
    end else if (frame_start) begin
      x_q <= '0;
      y_q <= '0;
    end
  end

  // Fixed-depth delay; empty slots carry all-zero entries so idle outputs read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_valid  = pipe_q[PIPE_LAT-1].vld;
  assign out_border = pipe_q[PIPE_LAT-1].border;
  assign out_x      = pipe_q[PIPE_LAT-1].x;
  assign out_y      = pipe_q[PIPE_LAT-1].y;
  assign frame_done = pipe_q[PIPE_LAT-1].last;

`ifdef LINE_WIN_STATS_EN
  logic        err_q;
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= frame_start & (state_q == S_ACTIVE);
      if (frame_done) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err_short = err_q;
  assign frame_cnt = cnt_q;
`else
  assign err_short = 1'b0;
  assign frame_cnt = '0;
`endif

endmodule
